// File: rtl/mult_share_pkg.sv
// Shared constants, helpers and the tag type for the multiplier-sharing arbiter.
// The tag id width is sized from the default requester count.
package mult_share_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF    = 32;
  localparam int unsigned MULT_LAT_DEF = 3;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W = id_w(NUM_REQ_DEF);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin arbiter: picks one eligible requester per cycle, starting the search at
// a registered pointer that moves to one past the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [NUM_REQ-1:0] busy_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     gnt_id_o,
  output logic               gnt_any_o
);

  logic [NUM_REQ-1:0] elig;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     idx;

  // No grant may be issued while reset is held.
  assign elig = req_valid_i & ~busy_i & {NUM_REQ{rst_n}};

  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any_o && elig[idx]) begin
        gnt_any_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (32'(gnt_id_o) == NUM_REQ - 1) ? '0 : gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters; a tag pipeline matching the
// multiplier latency routes each product into the owner's result register.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_in1,
  input  logic [NUM_REQ*WIDTH-1:0]     req_in2,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*2*WIDTH-1:0]   rsp_out,
  output logic [WIDTH-1:0]             mult_in1,
  output logic [WIDTH-1:0]             mult_in2,
  input  logic [2*WIDTH-1:0]           mult_out,
  output logic                         idle
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] hs;
  logic [2*WIDTH-1:0] rsp_out_q [NUM_REQ];
  logic [2*WIDTH-1:0] rsp_out_d [NUM_REQ];
  tag_t               tag_q [MULT_LAT];
  tag_t               tag_d [MULT_LAT];
  tag_t               tag_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdW     (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .busy_i      (busy_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_any_o   (gnt_any)
  );

  assign req_ready = gnt;
  assign hs        = rsp_valid_q & rsp_ready;
  assign tag_last  = tag_q[MULT_LAT-1];

  always_comb begin
    mult_in1 = '0;
    mult_in2 = '0;
    if (gnt_any) begin
      mult_in1 = req_in1[32'(gnt_id)*WIDTH +: WIDTH];
      mult_in2 = req_in2[32'(gnt_id)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    tag_d[0] = '{valid: gnt_any, id: gnt_id};
    for (int unsigned k = 1; k < MULT_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // A requester is never regranted while busy, so capture and handshake never collide.
  always_comb begin
    busy_d      = (busy_q | gnt) & ~hs;
    rsp_valid_d = rsp_valid_q & ~hs;
    rsp_out_d   = rsp_out_q;
    if (tag_last.valid) begin
      rsp_valid_d[tag_last.id] = 1'b1;
      rsp_out_d[tag_last.id]   = mult_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_out_q[i] <= '0;
      end
      for (int unsigned k = 0; k < MULT_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      tag_q       <= tag_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_out[i*2*WIDTH +: 2*WIDTH] = rsp_out_q[i];
  end

  assign rsp_valid = rsp_valid_q;
  // busy spans grant through response handshake, covering in-flight and pending ops.
  assign idle      = ~(|busy_q);

endmodule
